// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared state encoding, ASCII codes and address helper for the OSD menu
package osd_pkg;

    typedef enum logic [2:0] {
        INIT_CUR,
        INIT_VAL,
        IDLE,
        CUR_OLD,
        CUR_NEW,
        VAL_SIGN,
        VAL_TENS,
        VAL_UNITS
    } osd_state_t;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_GT    = 8'h3E;

    // Character RAM address of (row of item, col); rows past the screen wrap to the top.
    function automatic logic [10:0] char_addr(input int base_row, input int item,
                                              input int cols, input int rows, input int col);
        int row;
        int a;
        row = base_row + item;
        if (row >= rows) row = row - rows;
        a = row * cols + col;
        return 11'(a);
    endfunction

endpackage

// File: rtl/osd_key_repeat.sv
// rtl/osd_key_repeat.sv - key press to event pulse with hold-to-repeat
module osd_key_repeat #(
    parameter int REPEAT_DLY = 16_000_000,
    parameter int REPEAT_PER = 3_200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic ev
);

    logic        key_q;
    logic [31:0] cnt;

    // Fire on the press, then once the hold counter runs out, reloading with the repeat period.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
            cnt   <= '0;
            ev    <= 1'b0;
        end else begin
            key_q <= key;
            ev    <= 1'b0;
            if (!key) begin
                cnt <= '0;
            end else if (!key_q) begin
                ev  <= 1'b1;
                cnt <= 32'(REPEAT_DLY);
            end else if (cnt == 32'd1) begin
                ev  <= 1'b1;
                cnt <= 32'(REPEAT_PER);
            end else begin
                cnt <= cnt - 32'd1;
            end
        end
    end

endmodule

// File: rtl/osd_menu_ctrl.sv
// rtl/osd_menu_ctrl.sv - key-driven OSD menu with value editing and character RAM rendering
module osd_menu_ctrl
    import osd_pkg::*;
#(
    parameter int COLS        = 48,
    parameter int ROWS        = 32,
    parameter int NUM_ITEMS   = 4,
    parameter int VAL_W       = 6,
    parameter int BASE_ROW    = 12,
    parameter int CURSOR_COL  = 16,
    parameter int VALUE_COL   = 25,
    parameter int TIMEOUT_CYC = 128_000_000,
    parameter int REPEAT_DLY  = 16_000_000,
    parameter int REPEAT_PER  = 3_200_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_up,
    input  logic                       key_down,
    input  logic                       key_left,
    input  logic                       key_right,
    input  logic [NUM_ITEMS*VAL_W-1:0] cfg_min,
    input  logic [NUM_ITEMS*VAL_W-1:0] cfg_max,
    output logic [NUM_ITEMS*VAL_W-1:0] values,
    output logic [2:0]                 sel,
    output logic                       osd_active,
    output logic                       wr_req,
    output logic [10:0]                wr_addr,
    output logic [7:0]                 wr_data,
    input  logic                       wr_gnt
);

    osd_state_t              state;
    logic signed [VAL_W-1:0] val_r [NUM_ITEMS];
    logic [2:0]              item;
    logic [1:0]              fld;
    logic [31:0]             timer;

    logic ev_up, ev_down, ev_left, ev_right, any_ev;

    logic signed [VAL_W-1:0] cur_val, cur_min, cur_max, item_v;
    logic signed [7:0]       v8;
    logic [7:0]              mag, tens, units;
    logic [1:0]              fpos;
    logic [10:0]             nxt_addr;
    logic [7:0]              nxt_data;
    int                      col;

    osd_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_up (
        .clk(clk), .reset(reset), .key(key_up), .ev(ev_up));
    osd_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_down (
        .clk(clk), .reset(reset), .key(key_down), .ev(ev_down));
    osd_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_left (
        .clk(clk), .reset(reset), .key(key_left), .ev(ev_left));
    osd_key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_right (
        .clk(clk), .reset(reset), .key(key_right), .ev(ev_right));

    assign any_ev = ev_up | ev_down | ev_left | ev_right;

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_values
        assign values[g*VAL_W +: VAL_W] = val_r[g];
    end

    // Value and limits of the selected item, and value of the item being rendered.
    always_comb begin
        cur_val = '0;
        cur_min = '0;
        cur_max = '0;
        item_v  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel == i[2:0]) begin
                cur_val = val_r[i];
                cur_min = cfg_min[i*VAL_W +: VAL_W];
                cur_max = cfg_max[i*VAL_W +: VAL_W];
            end
            if (item == i[2:0]) item_v = val_r[i];
        end
    end

    // Address and character for the write the current state issues.
    always_comb begin
        v8    = {{(8-VAL_W){item_v[VAL_W-1]}}, item_v};
        mag   = v8[7] ? 8'(-v8) : 8'(v8);
        tens  = mag / 8'd10;
        units = mag % 8'd10;
        case (state)
            INIT_VAL:  fpos = fld;
            VAL_TENS:  fpos = 2'd1;
            VAL_UNITS: fpos = 2'd2;
            default:   fpos = 2'd0;
        endcase
        if (state == INIT_CUR || state == CUR_OLD || state == CUR_NEW) begin
            col      = CURSOR_COL;
            nxt_data = (state == CUR_NEW || (state == INIT_CUR && item == sel)) ? ASCII_GT : ASCII_SP;
        end else begin
            col = VALUE_COL + int'(fpos);
            case (fpos)
                2'd0:    nxt_data = v8[7] ? ASCII_MINUS : ASCII_PLUS;
                2'd1:    nxt_data = (mag < 8'd10) ? ASCII_SP : ASCII_ZERO + tens;
                default: nxt_data = ASCII_ZERO + units;
            endcase
        end
        nxt_addr = char_addr(BASE_ROW, int'(item), COLS, ROWS, col);
    end

    // Menu FSM: init render, key handling in IDLE, one handshaked write per render state, timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT_CUR;
            for (int i = 0; i < NUM_ITEMS; i++) val_r[i] <= '0;
            sel        <= '0;
            item       <= '0;
            fld        <= '0;
            timer      <= '0;
            osd_active <= 1'b0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (osd_active && timer != 32'd0) begin
                timer <= timer - 32'd1;
                if (timer == 32'd1) osd_active <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (any_ev) begin
                        timer      <= 32'(TIMEOUT_CYC);
                        osd_active <= 1'b1;
                        if (osd_active) begin
                            if (ev_up) begin
                                item  <= sel;
                                sel   <= (sel == 3'd0) ? 3'(NUM_ITEMS-1) : sel - 3'd1;
                                state <= CUR_OLD;
                            end else if (ev_down) begin
                                item  <= sel;
                                sel   <= (sel == 3'(NUM_ITEMS-1)) ? 3'd0 : sel + 3'd1;
                                state <= CUR_OLD;
                            end else if (ev_left) begin
                                if (cur_val > cur_min) begin
                                    for (int i = 0; i < NUM_ITEMS; i++)
                                        if (sel == i[2:0]) val_r[i] <= cur_val - VAL_W'(1);
                                    item  <= sel;
                                    state <= VAL_SIGN;
                                end
                            end else if (cur_val < cur_max) begin
                                for (int i = 0; i < NUM_ITEMS; i++)
                                    if (sel == i[2:0]) val_r[i] <= cur_val + VAL_W'(1);
                                item  <= sel;
                                state <= VAL_SIGN;
                            end
                        end
                    end
                end
                default: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= nxt_addr;
                        wr_data <= nxt_data;
                    end else if (wr_gnt) begin
                        wr_req <= 1'b0;
                        case (state)
                            INIT_CUR: begin
                                fld   <= 2'd0;
                                state <= INIT_VAL;
                            end
                            INIT_VAL: begin
                                if (fld == 2'd2) begin
                                    if (item == 3'(NUM_ITEMS-1)) begin
                                        state <= IDLE;
                                    end else begin
                                        item  <= item + 3'd1;
                                        state <= INIT_CUR;
                                    end
                                end else begin
                                    fld <= fld + 2'd1;
                                end
                            end
                            CUR_OLD: begin
                                item  <= sel;
                                state <= CUR_NEW;
                            end
                            VAL_SIGN: state <= VAL_TENS;
                            VAL_TENS: state <= VAL_UNITS;
                            default:  state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// tb/tb_osd_menu_ctrl.sv - directed self-checking bench for osd_menu_ctrl
module tb_osd_menu_ctrl;

    localparam int N  = 4;
    localparam int VW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    keys;
    logic [N*VW-1:0] cfg_min, cfg_max, values;
    logic [2:0]    sel;
    logic          osd_active, wr_req, wr_gnt;
    logic [10:0]   wr_addr;
    logic [7:0]    wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wq_addr[$];
    int wq_data[$];
    int ev_t[$];
    int exp_ev[6] = '{0, 10, 14, 18, 22, 26};
    int rise_t, fall_t, base;

    osd_menu_ctrl #(
        .NUM_ITEMS(N), .VAL_W(VW), .TIMEOUT_CYC(50), .REPEAT_DLY(10), .REPEAT_PER(4)
    ) dut (
        .clk(clk), .reset(reset),
        .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]), .key_right(keys[3]),
        .cfg_min(cfg_min), .cfg_max(cfg_max), .values(values), .sel(sel),
        .osd_active(osd_active), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && wr_req && wr_gnt) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int item_val(input int i);
        logic signed [VW-1:0] v;
        v = values[i*VW +: VW];
        return int'(v);
    endfunction

    function automatic int qa(input int i);
        return (i < wq_addr.size()) ? wq_addr[i] : -1;
    endfunction

    function automatic int qd(input int i);
        return (i < wq_data.size()) ? wq_data[i] : -1;
    endfunction

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic press(input int k);
        @(negedge clk) keys[k] = 1'b1;
        @(negedge clk) keys[k] = 1'b0;
    endtask

    // Left key wake (and optional second press); posedge 1 is the first edge seeing the key.
    task automatic measure(input bit second, output int r, output int f);
        r = 0;
        f = 0;
        keys[2] = 1'b1;
        for (int t = 1; t <= 150; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) keys[2] = 1'b0;
            if (second && t == 20) keys[2] = 1'b1;
            if (second && t == 21) keys[2] = 1'b0;
            if (r == 0 && osd_active) r = t;
            if (r != 0 && f == 0 && !osd_active) f = t;
        end
    endtask

    initial begin
        reset   = 1'b1;
        keys    = '0;
        wr_gnt  = 1'b1;
        cfg_min = {6'h36, 6'h36, 6'h36, 6'h36};
        cfg_max = {6'd20, 6'd20, 6'd20, 6'd12};
        repeat (3) @(posedge clk);
        #1;
        check("rst_osd_active", osd_active, 0);
        check("rst_sel", sel, 0);
        check("rst_values", int'(values), 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk) reset = 1'b0;

        repeat (50) @(negedge clk);
        check("init_writes", wq_addr.size(), 16);
        check("init_cur0_addr", qa(0), 592);
        check("init_cur0_data", qd(0), 8'h3E);
        check("init_sign_addr", qa(1), 601);
        check("init_sign_data", qd(1), 8'h2B);
        check("init_tens_addr", qa(2), 602);
        check("init_tens_data", qd(2), 8'h20);
        check("init_unit_addr", qa(3), 603);
        check("init_unit_data", qd(3), 8'h30);
        check("init_cur1_addr", qa(4), 640);
        check("init_cur1_data", qd(4), 8'h20);
        check("init_last_addr", qa(15), 747);
        check("init_osd_off", osd_active, 0);
        clear_q();

        press(1);
        repeat (8) @(negedge clk);
        check("wake_active", osd_active, 1);
        check("wake_sel", sel, 0);
        check("wake_no_writes", wq_addr.size(), 0);
        press(0);
        repeat (10) @(negedge clk);
        check("wrap_up_sel", sel, 3);
        check("wrap_up_writes", wq_addr.size(), 2);
        check("wrap_up_old_addr", qa(0), 592);
        check("wrap_up_old_data", qd(0), 8'h20);
        check("wrap_up_new_addr", qa(1), 736);
        check("wrap_up_new_data", qd(1), 8'h3E);
        clear_q();

        wr_gnt = 1'b0;
        press(3);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_wr_req", wr_req, 1);
            check("bp_wr_addr", wr_addr, 745);
            check("bp_wr_data", wr_data, 8'h2B);
            if (k == 1) keys[1] = 1'b1;
            if (k == 2) keys[1] = 1'b0;
            @(negedge clk);
        end
        wr_gnt = 1'b1;
        repeat (12) @(negedge clk);
        check("bp_sel_kept", sel, 3);
        check("bp_value3", item_val(3), 1);
        check("bp_writes", wq_addr.size(), 3);
        check("bp_unit_addr", qa(2), 747);
        check("bp_unit_data", qd(2), 8'h31);
        clear_q();

        press(1);
        repeat (8) @(negedge clk);
        check("wrap_down_sel", sel, 0);
        check("wrap_down_new_addr", qa(1), 592);
        clear_q();

        @(negedge clk) keys[3] = 1'b1;
        repeat (200) @(negedge clk);
        keys[3] = 1'b0;
        base = wq_addr.size();
        check("sat_value0", item_val(0), 12);
        check("sat_writes", base, 36);
        check("sat_sign_addr", qa(base-3), 601);
        check("sat_sign_data", qd(base-3), 8'h2B);
        check("sat_tens_data", qd(base-2), 8'h31);
        check("sat_unit_addr", qa(base-1), 603);
        check("sat_unit_data", qd(base-1), 8'h32);
        for (int t = 0; t < 200 && osd_active; t++) @(negedge clk);
        check("sat_then_timeout", osd_active, 0);
        clear_q();

        @(negedge clk);
        measure(1'b0, rise_t, fall_t);
        check("to_rise", rise_t, 2);
        check("to_fall", fall_t, 52);
        check("to_wake_value", item_val(0), 12);
        measure(1'b1, rise_t, fall_t);
        check("to_restart_fall", fall_t, 72);
        check("to_restart_value", item_val(0), 11);
        check("to_restart_unit", qd(2), 8'h31);

        repeat (5) @(negedge clk);
        keys[2] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk);
            #1;
            if (t == 30) keys[2] = 1'b0;
            if (dut.u_rep_left.ev) ev_t.push_back(t - 1);
        end
        check("rep_count", ev_t.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("rep_ev%0d", i), (i < ev_t.size()) ? ev_t[i] : -1, exp_ev[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
